// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch control slice.
// State encoding, BCD digit layout and event priority live here.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  // Highest priority first: clear, start, lap.
  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_CLEAR = 2'd1,
    EV_START = 2'd2,
    EV_LAP   = 2'd3
  } sw_event_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int DIG_W     = 4;
  localparam int DIG_NUM   = 4;
  localparam int DIG_HUND  = 0;
  localparam int DIG_TENTH = 4;
  localparam int DIG_SEC   = 8;
  localparam int DIG_TSEC  = 12;

  localparam logic [15:0] BCD_TOP = {4{BCD_MAX}};

  // One event per cycle; lower-priority presses are dropped.
  function automatic sw_event_e pick_event(
    input logic clr,
    input logic start,
    input logic lap
  );
    sw_event_e ev;
    if (clr)
      ev = EV_CLEAR;
    else if (start)
      ev = EV_START;
    else if (lap)
      ev = EV_LAP;
    else
      ev = EV_NONE;
    return ev;
  endfunction

  // Ripple a +1 through four BCD digits, wrapping 99.99 to 00.00.
  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIG_NUM; i++) begin
      if (c) begin
        if (r[i*DIG_W +: DIG_W] == BCD_MAX) begin
          r[i*DIG_W +: DIG_W] = '0;
        end else begin
          r[i*DIG_W +: DIG_W] = r[i*DIG_W +: DIG_W] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-FF sync, tick-gated stability count,
// and a one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk_100M,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_MS - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          lvl_q;
  logic          lvl_d;
  logic          lvl_dly_q;
  logic          press_q;

  // Count stable ticks that disagree with the accepted level.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (sync_q[1] == lvl_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Sync, level register and rising-edge pulse.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      press_q   <= lvl_q & ~lvl_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: 1 kHz tick, button FSM, prescaler,
// 4-digit BCD time (SS.CC) and lap freeze for the display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_CS = 10,
  parameter int DEB_MS       = 20
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        clk_1K,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        ovf,
  output logic [1:0]  state
);

  localparam int PW =
    (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [PW-1:0] PS_LAST =
    PW'(TICKS_PER_CS - 1);

  logic [2:0]    k_sync_q;
  logic          tick_q;

  logic          p_start;
  logic          p_lap;
  logic          p_clr;
  sw_event_e     ev;

  sw_state_e     state_q;
  logic          run_q;
  logic          lap_act_q;
  logic [15:0]   lap_bcd_q;

  logic [PW-1:0] psc_q;
  logic [PW-1:0] psc_d;
  logic          cs_inc_q;
  logic          cs_inc_d;

  logic [15:0]   cnt_q;
  logic [15:0]   cnt_d;
  logic          ovf_q;
  logic          ovf_d;

  logic          counting;
  logic          zero_req;

  // Sync clk_1K and pulse tick on its rising edge.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      k_sync_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      k_sync_q <= {k_sync_q[1:0], clk_1K};
      tick_q   <= k_sync_q[1] & ~k_sync_q[2];
    end
  end

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_start (
    .clk_100M (clk_100M),
    .rst      (rst),
    .tick_i   (tick_q),
    .btn_i    (btn_start),
    .press_o  (p_start)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_lap (
    .clk_100M (clk_100M),
    .rst      (rst),
    .tick_i   (tick_q),
    .btn_i    (btn_lap),
    .press_o  (p_lap)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_clear (
    .clk_100M (clk_100M),
    .rst      (rst),
    .tick_i   (tick_q),
    .btn_i    (btn_clear),
    .press_o  (p_clr)
  );

  assign ev = pick_event(p_clr, p_start, p_lap);

  assign counting = (state_q == ST_RUN) ||
                    (state_q == ST_LAP);

  // IDLE holds zero; clear from PAUSE zeroes at once.
  assign zero_req = (state_q == ST_IDLE) ||
                    ((state_q == ST_PAUSE) &&
                     (ev == EV_CLEAR));

  // Prescaler next state: divide ticks down to centiseconds.
  always_comb begin
    psc_d    = psc_q;
    cs_inc_d = 1'b0;
    if (zero_req) begin
      psc_d = '0;
    end else if (counting && tick_q) begin
      if (psc_q == PS_LAST) begin
        psc_d    = '0;
        cs_inc_d = 1'b1;
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  // BCD counter next state; cs_inc is honoured in any state.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (zero_req) begin
      cnt_d = '0;
    end else if (cs_inc_q) begin
      cnt_d = bcd_inc(cnt_q);
      ovf_d = (cnt_q == BCD_TOP);
    end
  end

  // Prescaler, live counter and wrap pulse registers.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      psc_q    <= '0;
      cs_inc_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      psc_q    <= psc_d;
      cs_inc_q <= cs_inc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Control FSM with registered status flags and lap latch.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      lap_act_q <= 1'b0;
      lap_bcd_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ev == EV_START) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ev == EV_START) begin
            state_q <= ST_PAUSE;
            run_q   <= 1'b0;
          end else if (ev == EV_LAP) begin
            state_q   <= ST_LAP;
            lap_act_q <= 1'b1;
            lap_bcd_q <= cnt_q;
          end
        end
        ST_LAP: begin
          if (ev == EV_START) begin
            state_q   <= ST_PAUSE;
            run_q     <= 1'b0;
            lap_act_q <= 1'b0;
          end else if (ev == EV_LAP) begin
            state_q   <= ST_RUN;
            lap_act_q <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (ev == EV_CLEAR) begin
            state_q <= ST_IDLE;
          end else if (ev == EV_START) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign disp_bcd   = lap_act_q ? lap_bcd_q : cnt_q;
  assign running    = run_q;
  assign lap_active = lap_act_q;
  assign ovf        = ovf_q;
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with fast prescale and
// short debounce; ticks are delivered one clk_1K pulse at a time.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;

  logic        clk_100M;
  logic        rst;
  logic        clk_1K;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic [15:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        ovf;
  logic [1:0]  state;

  int n_cmp;
  int n_bad;
  int ovf_cnt;
  logic [15:0] ovf_disp;

  stopwatch_ctrl #(
    .TICKS_PER_CS (1),
    .DEB_MS       (DEB)
  ) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .clk_1K     (clk_1K),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .btn_clear  (btn_clear),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf),
    .state      (state)
  );

  initial begin
    clk_100M = 1'b0;
    forever #5 clk_100M = ~clk_100M;
  end

  always @(negedge clk_100M) begin
    if (ovf === 1'b1) begin
      ovf_cnt  = ovf_cnt + 1;
      ovf_disp = disp_bcd;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // n clk_1K pulses of 4 clk_100M cycles, then let it settle.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      clk_1K = 1'b1;
      #20;
      clk_1K = 1'b0;
      #20;
    end
    repeat (8) @(negedge clk_100M);
  endtask

  // m = {clear, lap, start}: hold DEB ticks, release DEB ticks.
  task automatic press(input logic [2:0] m);
    {btn_clear, btn_lap, btn_start} = m;
    tick(DEB);
    {btn_clear, btn_lap, btn_start} = 3'b000;
    tick(DEB);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    ovf_cnt   = 0;
    ovf_disp  = '0;
    rst       = 1'b1;
    clk_1K    = 1'b0;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;

    tick(3);
    chk("rst_disp", disp_bcd, 16'h0000);
    chk("rst_state", 16'(state), 16'd0);
    rst = 1'b0;
    tick(20);
    chk("idle_disp", disp_bcd, 16'h0000);
    chk("idle_state", 16'(state), 16'd0);
    chk("idle_run", 16'(running), 16'd0);
    chk("idle_ovf", 16'(ovf), 16'd0);
    chk("idle_lap", 16'(lap_active), 16'd0);

    press(3'b001);
    chk("start_state", 16'(state), 16'd1);
    chk("start_run", 16'(running), 16'd1);
    tick(996);
    chk("run_1000", disp_bcd, 16'h1000);

    press(3'b001);
    chk("pause_state", 16'(state), 16'd3);
    chk("pause_run", 16'(running), 16'd0);
    chk("pause_disp", disp_bcd, 16'h1004);
    tick(500);
    chk("pause_hold", disp_bcd, 16'h1004);

    btn_start = 1'b1; tick(1);
    btn_start = 1'b0; tick(1);
    btn_start = 1'b1; tick(2);
    btn_start = 1'b0; tick(1);
    btn_start = 1'b1; tick(3);
    btn_start = 1'b0; tick(1);
    btn_start = 1'b1; tick(3);
    btn_start = 1'b0; tick(1);
    btn_start = 1'b1; tick(2);
    btn_start = 1'b0; tick(1);
    chk("glitch_state", 16'(state), 16'd3);
    chk("glitch_disp", disp_bcd, 16'h1004);

    btn_start = 1'b1; tick(2);
    btn_start = 1'b0; tick(1);
    btn_start = 1'b1; tick(1);
    btn_start = 1'b0; tick(1);
    btn_start = 1'b1; tick(DEB);
    chk("bounce_state", 16'(state), 16'd1);
    tick(8);
    chk("hold_state", 16'(state), 16'd1);
    btn_start = 1'b0; tick(DEB);
    chk("hold_disp", disp_bcd, 16'h1016);

    press(3'b100);
    chk("clr_run_ign", 16'(state), 16'd1);
    press(3'b001);
    chk("pause2_disp", disp_bcd, 16'h1028);
    press(3'b100);
    chk("clr_state", 16'(state), 16'd0);
    chk("clr_disp", disp_bcd, 16'h0000);

    press(3'b001);
    tick(242);
    press(3'b010);
    chk("lap_state", 16'(state), 16'd2);
    chk("lap_flag", 16'(lap_active), 16'd1);
    chk("lap_running", 16'(running), 16'd1);
    chk("lap_disp", disp_bcd, 16'h0250);
    tick(88);
    chk("lap_frozen", disp_bcd, 16'h0250);
    press(3'b010);
    chk("unlap_state", 16'(state), 16'd1);
    chk("unlap_flag", 16'(lap_active), 16'd0);
    chk("unlap_disp", disp_bcd, 16'h0350);

    press(3'b001);
    chk("pause3_state", 16'(state), 16'd3);
    press(3'b101);
    chk("both_state", 16'(state), 16'd0);
    chk("both_disp", disp_bcd, 16'h0000);

    press(3'b001);
    ovf_cnt = 0;
    tick(9995);
    chk("pre_wrap", disp_bcd, 16'h9999);
    chk("pre_ovf", 16'(ovf_cnt), 16'd0);
    tick(1);
    chk("wrap_ovf", 16'(ovf_cnt), 16'd1);
    chk("wrap_coinc", ovf_disp, 16'h0000);
    chk("wrap_disp", disp_bcd, 16'h0000);
    tick(5);
    chk("post_wrap", disp_bcd, 16'h0005);
    chk("post_ovf", 16'(ovf_cnt), 16'd1);
    chk("post_state", 16'(state), 16'd1);

    @(negedge clk_100M);
    #2 rst = 1'b1;
    #1;
    chk("arst_disp", disp_bcd, 16'h0000);
    chk("arst_state", 16'(state), 16'd0);
    chk("arst_run", 16'(running), 16'd0);
    chk("arst_lap", 16'(lap_active), 16'd0);
    chk("arst_ovf", 16'(ovf), 16'd0);
    #27 rst = 1'b0;
    tick(10);
    chk("restart_state", 16'(state), 16'd0);
    chk("restart_disp", disp_bcd, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
